// File: rtl/matmult_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// matmult_scheduler_pkg
//   Shared definitions for the matrix-multiply job scheduler:
//     - EXECYCLE : kernel execution length in cycles (overridable by a
//                  compile-time define of the same name).
//     - PASS_CYC_DEFAULT : spacing between consecutive kernel Start pulses.
//       The kernel needs EXECYCLE cycles plus two cycles of turnaround.
//     - state_t  : scheduler FSM encoding (IDLE must stay 0 so that a reset
//                  drives the exported state to all zeros).
// -----------------------------------------------------------------------------
`ifndef EXECYCLE
`define EXECYCLE 16
`endif

package matmult_scheduler_pkg;

    localparam int EXECYCLE         = `EXECYCLE;
    localparam int PASS_CYC_DEFAULT = EXECYCLE + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin picker.
//   When both requests are high, the requester that was not granted most
//   recently wins. After reset requester 0 has priority.
//
// Ports
//   Clk     in  1   rising-edge clock
//   Rst_n   in  1   asynchronous active-low reset (priority -> requester 0)
//   req     in  2   request vector
//   update  in  1   commit the current grant into the priority pointer
//   gnt     out 2   one-hot (or zero) grant, combinational from req
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // prio_q names the requester that wins a tie.
    logic prio_q;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~prio_q);
        gnt[1] = req[1] & (~req[0] |  prio_q);
    end

    // After a grant, the other requester gets the tie-break.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_q <= 1'b0;
        end else if (update) begin
            if (gnt[0]) begin
                prio_q <= 1'b1;
            end else if (gnt[1]) begin
                prio_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matmult_scheduler.sv
// -----------------------------------------------------------------------------
// matmult_scheduler
//   Schedules multi-pass jobs from two requesters onto one matmult kernel.
//   A job of Len passes issues one Kern_start per pass, PASS_CYC cycles
//   apart, then pulses Done of its owner. Abort ends a job at the next pass
//   boundary; a pass already started always runs to its boundary.
//
// Handshake
//   ReqN is a level held by requester N until it sees GntN (one-cycle pulse).
//   LenN is sampled on the grant edge only; later changes are ignored, as is
//   a Req dropped while the job runs. DoneN pulses once per granted job with
//   Aborted qualifying it; a job killed by reset produces no Done.
//
// Timeline for a Len=L job (cycle 0 = the cycle Gnt is high)
//   Kern_start at 0, PASS_CYC, 2*PASS_CYC, ... ; Done at L*PASS_CYC;
//   one IDLE cycle follows before the next grant can appear.
//   Len=0: Done appears at cycle 1, no Kern_start.
//
// Ports
//   Clk         in  1     rising-edge clock
//   Rst_n       in  1     asynchronous active-low reset
//   Req0, Req1  in  1     job requests (level)
//   Len0, Len1  in  LENW  passes requested
//   Abort       in  1     stop active job at next pass boundary
//   Gnt0, Gnt1  out 1     grant pulses
//   Kern_start  out 1     kernel Start pulse
//   Pass_idx    out LENW  pass currently in the kernel (address-bank offset)
//   Owner       out 1     requester owning the kernel, valid while Busy
//   Busy        out 1     a job is active
//   Done0,Done1 out 1     completion pulses
//   Aborted     out 1     qualifies Done: job ended early
//   State       out 2     FSM state (debug observation)
// -----------------------------------------------------------------------------
module matmult_scheduler
    import matmult_scheduler_pkg::*;
#(
    parameter int LENW     = 4,
    parameter int PASS_CYC = PASS_CYC_DEFAULT
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Req0,
    input  logic            Req1,
    input  logic [LENW-1:0] Len0,
    input  logic [LENW-1:0] Len1,
    input  logic            Abort,
    output logic            Gnt0,
    output logic            Gnt1,
    output logic            Kern_start,
    output logic [LENW-1:0] Pass_idx,
    output logic            Owner,
    output logic            Busy,
    output logic            Done0,
    output logic            Done1,
    output logic            Aborted,
    output state_t          State
);

    localparam int TW = cnt_width(PASS_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PASS_CYC - 1);

    // -------------------------------------------------------------------------
    // Arbitration: only consulted while IDLE; the pointer moves on a grant.
    // -------------------------------------------------------------------------
    logic [1:0]      arb_req;
    logic [1:0]      arb_gnt;
    logic            arb_update;
    logic [LENW-1:0] sel_len;

    assign arb_req    = {Req1, Req0};
    assign arb_update = (State == ST_IDLE) && (arb_gnt != 2'b00);
    assign sel_len    = arb_gnt[1] ? Len1 : Len0;

    rr_arb2 u_arb (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .req    (arb_req),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // -------------------------------------------------------------------------
    // Job state
    // -------------------------------------------------------------------------
    logic [LENW-1:0] len_q;     // passes latched at grant
    logic [TW-1:0]   timer_q;   // cycle within the current pass
    logic            abort_q;   // sticky abort for the active job

    logic pass_boundary;
    logic last_pass;
    logic stop_now;

    assign pass_boundary = (timer_q == TIMER_LAST);
    assign last_pass     = (Pass_idx == (len_q - LENW'(1)));
    // An Abort arriving in the boundary cycle itself also counts.
    assign stop_now      = last_pass || abort_q || Abort;

    // -------------------------------------------------------------------------
    // FSM. Pulse outputs are registered on entry to the state that owns them:
    // Kern_start is high during the START cycle (which is pass cycle 0), and
    // Done is high during the final DONE cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            State      <= ST_IDLE;
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            Kern_start <= 1'b0;
            Pass_idx   <= '0;
            Owner      <= 1'b0;
            Busy       <= 1'b0;
            Done0      <= 1'b0;
            Done1      <= 1'b0;
            Aborted    <= 1'b0;
            len_q      <= '0;
            timer_q    <= '0;
            abort_q    <= 1'b0;
        end else begin
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            Kern_start <= 1'b0;

            if (Abort && Busy) begin
                abort_q <= 1'b1;
            end

            case (State)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (arb_gnt != 2'b00) begin
                        Gnt0     <= arb_gnt[0];
                        Gnt1     <= arb_gnt[1];
                        Owner    <= arb_gnt[1];
                        len_q    <= sel_len;
                        Pass_idx <= '0;
                        timer_q  <= '0;
                        Busy     <= 1'b1;
                        if (sel_len != '0) begin
                            Kern_start <= 1'b1;
                            State      <= ST_START;
                        end else begin
                            State <= ST_DONE;
                        end
                    end
                end

                ST_START: begin
                    // The START cycle was timer value 0.
                    timer_q <= TW'(1);
                    State   <= ST_RUN;
                end

                ST_RUN: begin
                    if (pass_boundary) begin
                        timer_q <= '0;
                        if (stop_now) begin
                            Done0   <= ~Owner;
                            Done1   <= Owner;
                            Aborted <= abort_q | Abort;
                            State   <= ST_DONE;
                        end else begin
                            Pass_idx   <= Pass_idx + LENW'(1);
                            Kern_start <= 1'b1;
                            State      <= ST_START;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                ST_DONE: begin
                    if (Done0 || Done1) begin
                        // Done has been shown; release the kernel.
                        Done0   <= 1'b0;
                        Done1   <= 1'b0;
                        Aborted <= 1'b0;
                        Busy    <= 1'b0;
                        abort_q <= 1'b0;
                        State   <= ST_IDLE;
                    end else begin
                        // Arrived straight from a Len=0 grant: the Done pulse
                        // still has to be issued.
                        Done0   <= ~Owner;
                        Done1   <= Owner;
                        Aborted <= abort_q | Abort;
                    end
                end

                default: begin
                    State <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmult_scheduler.sv
module tb_matmult_scheduler;
    import matmult_scheduler_pkg::*;

    localparam int LENW     = 4;
    localparam int PASS_CYC = 18;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            Rst_n;
    logic            Req0, Req1, Abort;
    logic [LENW-1:0] Len0, Len1;
    logic            Gnt0, Gnt1, Kern_start, Owner, Busy, Done0, Done1, Aborted;
    logic [LENW-1:0] Pass_idx;
    state_t          State;

    matmult_scheduler #(.LENW(LENW), .PASS_CYC(PASS_CYC)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req0       (Req0),
        .Req1       (Req1),
        .Len0       (Len0),
        .Len1       (Len1),
        .Abort      (Abort),
        .Gnt0       (Gnt0),
        .Gnt1       (Gnt1),
        .Kern_start (Kern_start),
        .Pass_idx   (Pass_idx),
        .Owner      (Owner),
        .Busy       (Busy),
        .Done0      (Done0),
        .Done1      (Done1),
        .Aborted    (Aborted),
        .State      (State)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];   // expected Kern_start cycles
    logic [31:0] kern_q[$];  // observed Kern_start cycles
    logic [31:0] idx_q[$];   // Pass_idx seen with each Kern_start

    int gnt0_c, gnt1_c, done0_c, done1_c;
    logic aborted_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver / monitor: observe ncyc cycles numbered from 0 at the next
    // edge. Requesters drop Req and scramble Len once granted. Abort is
    // driven high during cycle abort_at (negative = never).
    // ------------------------------------------------------------------
    task automatic watch(input int ncyc, input int abort_at);
        gnt0_c = -1; gnt1_c = -1; done0_c = -1; done1_c = -1;
        aborted_v = 1'b0;
        kern_q.delete();
        idx_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge Clk);
            #1;
            if (Kern_start) begin
                kern_q.push_back(c);
                idx_q.push_back(32'(Pass_idx));
            end
            if (Gnt0) begin gnt0_c = c; Req0 = 1'b0; Len0 = ~Len0; end
            if (Gnt1) begin gnt1_c = c; Req1 = 1'b0; Len1 = ~Len1; end
            if (Done0) begin done0_c = c; aborted_v = Aborted; end
            if (Done1) begin done1_c = c; aborted_v = Aborted; end
            Abort = (c + 1 == abort_at);
        end
        Abort = 1'b0;
    endtask

    task automatic cmp_kern(input string tag);
        check_eq({tag, "_kern_cnt"}, kern_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < kern_q.size(); i++) begin
            check_eq({tag, "_kern_cyc"}, kern_q[i], exp_q[i]);
            check_eq({tag, "_pass_idx"}, idx_q[i], i);
        end
    endtask

    task automatic set_exp_kern(input int n, input int step);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(i * step);
    endtask

    task automatic start_req(input logic r0, input logic [LENW-1:0] l0,
                             input logic r1, input logic [LENW-1:0] l1);
        @(posedge Clk);
        #1;
        Req0 = r0; Len0 = l0; Req1 = r1; Len1 = l1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        Rst_n = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Abort = 1'b0;
        Len0 = '0; Len1 = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_busy",  Busy, 0);
        check_eq("rst_kern",  Kern_start, 0);
        check_eq("rst_state", 32'(State), 32'(ST_IDLE));
        check_eq("rst_gnt",   {Gnt1, Gnt0}, 0);
        check_eq("rst_done",  {Done1, Done0, Aborted}, 0);
        Rst_n = 1'b1;

        // Both requesters on the same edge, Len=1 each: Req0 first.
        start_req(1'b1, 4'd1, 1'b1, 4'd1);
        watch(45, -1);
        check_eq("rr_gnt0",  gnt0_c, 0);
        check_eq("rr_done0", done0_c, 18);
        check_eq("rr_gnt1",  gnt1_c, 20);
        check_eq("rr_done1", done1_c, 38);
        exp_q.delete(); exp_q.push_back(0); exp_q.push_back(20);
        check_eq("rr_kern_cnt", kern_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < kern_q.size(); i++)
            check_eq("rr_kern_cyc", kern_q[i], exp_q[i]);

        // Req0, Len0=3.
        start_req(1'b1, 4'd3, 1'b0, 4'd0);
        watch(60, -1);
        check_eq("l3_gnt0",    gnt0_c, 0);
        check_eq("l3_done0",   done0_c, 54);
        check_eq("l3_done1",   done1_c, -1);
        check_eq("l3_aborted", aborted_v, 0);
        set_exp_kern(3, PASS_CYC);
        cmp_kern("l3");
        check_eq("l3_busy_end", Busy, 0);

        // Req1, Len1=0.
        start_req(1'b0, 4'd5, 1'b1, 4'd0);
        watch(6, -1);
        check_eq("l0_gnt1",  gnt1_c, 1 - 1);
        check_eq("l0_done1", done1_c, 1);
        check_eq("l0_done0", done0_c, -1);
        check_eq("l0_kern",  kern_q.size(), 0);

        // Len=4 with Abort during cycle 5.
        start_req(1'b1, 4'd4, 1'b0, 4'd0);
        watch(25, 5);
        check_eq("ab_done0",   done0_c, 18);
        check_eq("ab_aborted", aborted_v, 1);
        set_exp_kern(1, PASS_CYC);
        cmp_kern("ab");

        // Abort while idle is ignored; next job completes normally.
        @(posedge Clk); #1; Abort = 1'b1;
        @(posedge Clk); #1; Abort = 1'b0;
        start_req(1'b1, 4'd1, 1'b0, 4'd0);
        watch(22, -1);
        check_eq("ab2_done0",   done0_c, 18);
        check_eq("ab2_aborted", aborted_v, 0);

        // Maximum length.
        start_req(1'b1, 4'd15, 1'b0, 4'd0);
        watch(275, -1);
        check_eq("max_done0", done0_c, 270);
        set_exp_kern(15, PASS_CYC);
        cmp_kern("max");
        if (idx_q.size() > 0) check_eq("max_last_idx", idx_q[idx_q.size()-1], 14);
        else check_eq("max_last_idx", 32'hFFFF_FFFF, 14);

        // Reset in the middle of a Len=3 job.
        start_req(1'b1, 4'd3, 1'b0, 4'd0);
        watch(25, -1);
        @(posedge Clk);
        #1;
        check_eq("mid_busy_pre", Busy, 1);
        Rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy",  Busy, 0);
        check_eq("mid_rst_state", 32'(State), 32'(ST_IDLE));
        check_eq("mid_rst_outs",  {Gnt0, Gnt1, Kern_start, Owner, Done0, Done1, Aborted}, 0);
        check_eq("mid_rst_idx",   32'(Pass_idx), 0);
        done0_c = -1;
        repeat (3) begin
            @(posedge Clk); #1;
            if (Done0 || Done1) done0_c = 1;
        end
        check_eq("mid_rst_nodone", done0_c, -1);
        Rst_n = 1'b1;
        start_req(1'b1, 4'd1, 1'b1, 4'd1);
        watch(4, -1);
        check_eq("mid_gnt0", gnt0_c, 0);
        check_eq("mid_gnt1", gnt1_c, -1);
        check_eq("mid_done", done0_c, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
